// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: latches a load/store, runs the strobe/ready handshake with a
// timeout abort, and freezes the pipeline meanwhile. Define MEM_READ_BYPASS_EN for a one-entry read buffer.
//
// state  | meaning
// IDLE   | waiting for a pipeline load/store; strobes low
// ACCESS | strobe held to memory until mem_ready or timeout
// DONE   | one-cycle release so the pipeline advances; requests ignored
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              freeze,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // ACCESS may last TIMEOUT cycles; the abort fires on the last of them.
  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        timer;
  logic              req_any;
  logic              timeout_hit;
  logic              bypass_hit;
  logic [DATA_W-1:0] bypass_data;

  assign req_any     = req_read | req_write;
  assign timeout_hit = (state == ACCESS) && !mem_ready && (timer == TIMEOUT_TC);
  assign freeze      = ((state == IDLE) && req_any) || (state == ACCESS);

`ifdef MEM_READ_BYPASS_EN
  logic              buf_valid;
  logic [ADDR_W-3:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  assign bypass_hit  = req_read && !req_write && buf_valid && (buf_addr == req_addr[ADDR_W-1:2]);
  assign bypass_data = buf_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (state == ACCESS) begin
      if (mem_ready) begin
        if (mem_read) begin
          buf_valid <= 1'b1;
          buf_addr  <= mem_address[ADDR_W-1:2];
          buf_data  <= mem_rdata;
        end else if (buf_valid && (buf_addr == mem_address[ADDR_W-1:2])) begin
          buf_data <= mem_wdata;
        end
      end else if (timeout_hit) begin
        buf_valid <= 1'b0;
      end
    end
  end
`else
  assign bypass_hit  = 1'b0;
  assign bypass_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      err         <= 1'b0;
      rdata_out   <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            // Simultaneous read+write is illegal: flagged, then issued as a write.
            if (req_read && req_write) err <= 1'b1;
            if (bypass_hit) begin
              rdata_out <= bypass_data;
              state     <= DONE;
            end else begin
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata   <= req_wdata;
              mem_write   <= req_write;
              mem_read    <= !req_write;
              timer       <= '0;
              state       <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (mem_read) rdata_out <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            rdata_out <= '0;
            err       <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model of the memory interface.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rdata_out;
  logic        freeze;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata_out(rdata_out),
    .freeze(freeze), .err(err), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] m_rdata;
  bit          m_err;
  bit          m_buf_valid;
  logic [29:0] m_buf_waddr;
  logic [31:0] m_buf_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_rdata     = '0;
    m_err       = 1'b0;
    m_buf_valid = 1'b0;
    m_buf_waddr = '0;
    m_buf_data  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_read = 0; req_write = 0; mem_ready = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // wait_n: non-ready ACCESS cycles before mem_ready; negative means the memory never answers.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_n, input logic [31:0] rdata);
    bit hit;
    bit timed_out;
    int exp_access;
    int frz;
    hit = 1'b0;
`ifdef MEM_READ_BYPASS_EN
    hit = rd && !wr && m_buf_valid && (m_buf_waddr == addr[31:2]);
`endif
    timed_out  = !hit && !(wait_n >= 0 && wait_n < TIMEOUT);
    exp_access = hit ? 0 : (timed_out ? TIMEOUT : wait_n + 1);
    if (rd && wr) m_err = 1'b1;
    if (hit) m_rdata = m_buf_data;
    else if (timed_out) begin
      m_rdata = '0;
      m_err = 1'b1;
      m_buf_valid = 1'b0;
    end else if (!wr) begin
      m_rdata = rdata;
      m_buf_valid = 1'b1;
      m_buf_waddr = addr[31:2];
      m_buf_data = rdata;
    end else if (m_buf_valid && m_buf_waddr == addr[31:2]) m_buf_data = wdata;

    @(negedge clk);
    #1;
    check("idle_freeze", freeze, 0);
    check("idle_strobe", {mem_read, mem_write}, 2'b00);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata; mem_ready = 0;
    #1 check("req_freeze", freeze, 1);
    frz = 0;
    do begin
      frz++;
      @(posedge clk);
      @(negedge clk);
      #1;
      if (freeze) begin
        check("strobe", {mem_read, mem_write}, {!wr, wr});
        check("mem_address", mem_address, {addr[31:2], 2'b00});
        check("mem_wdata", mem_wdata, wdata);
        mem_ready = (frz - 1 == wait_n);
        mem_rdata = mem_ready ? rdata : $urandom;
        // requests wiggling mid-access must be ignored
        req_read  = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
    end while (freeze && frz < 600);
    req_read = 0; req_write = 0; mem_ready = 0;
    check("freeze_cycles", frz, 1 + exp_access);
    check("done_strobe", {mem_read, mem_write}, 2'b00);
    check("rdata_out", rdata_out, m_rdata);
    check("err", err, m_err);
  endtask

  task automatic random_phase(input int n, input bit allow_illegal);
    logic [31:0] a;
    bit rd, wr;
    int w;
    for (int i = 0; i < n; i++) begin
      a  = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 2) == 0);
      rd = !wr || (allow_illegal && $urandom_range(0, 7) == 0);
      w  = $urandom_range(0, 5);
      run_txn(rd, wr, a, $urandom, w, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    #12;
    #1;
    check("rst_freeze", freeze, 0);
    check("rst_strobe", {mem_read, mem_write}, 2'b00);
    check("rst_rdata", rdata_out, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_address, 0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h403, 32'h0, 3, 32'h12345678);
    random_phase(40, 1'b0);
    run_txn(1'b1, 1'b1, 32'h404, 32'hA5A5A5A5, 1, 32'h0);

    apply_reset();
    #1 check("rst_err_clear", err, 0);
    check("rst_rdata_clear", rdata_out, 0);

    // asynchronous reset in the middle of a store
    @(negedge clk);
    req_write = 1; req_read = 0; req_addr = 32'h500; req_wdata = 32'h1111_2222; mem_ready = 0;
    @(negedge clk);
    req_write = 0;
    #1 check("pre_rst_strobe", mem_write, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_strobe", {mem_read, mem_write}, 2'b00);
    check("async_rst_freeze", freeze, 0);
    check("async_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_txn(1'b0, 1'b1, 32'h504, 32'h3333_4444, 2, 32'h0);

    run_txn(1'b1, 1'b0, 32'h408, 32'h0, 0, 32'hCAFEF00D);
    run_txn(1'b1, 1'b0, 32'h408, 32'h0, 0, 32'h0BADBAD0);
    run_txn(1'b0, 1'b1, 32'h40A, 32'h55, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h408, 32'h0, 0, 32'h55);

    run_txn(1'b1, 1'b0, 32'h40C, 32'h0, -1, 32'h0);
    run_txn(1'b1, 1'b0, 32'h40C, 32'h0, 1, 32'h7777_8888);

    apply_reset();
    random_phase(30, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
